// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and boot image for the loadable instruction memory
//
// Holds the sequencer state type, the NOP encoding and the boot image.
// Optional feature macro: INSTR_MEM_BOOT_PROG_EN
//   defined   -> boot_word() returns the five-instruction boot program, 0 beyond it
//   undefined -> boot_word() returns NOP for every address
package instr_mem_pkg;

  typedef enum logic [1:0] {INIT, IDLE, LOAD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int BOOT_LEN = 5;

  localparam logic [31:0] BOOT_IMAGE [BOOT_LEN] = '{
    32'h200100CA,  // ADDI $1,$0,0xCA
    32'h00211020,  // ADD  $2,$1,$1
    32'h00421820,  // ADD  $3,$2,$2
    32'h00632020,  // ADD  $4,$3,$3
    32'h00842820   // ADD  $5,$4,$4
  };

`ifdef INSTR_MEM_BOOT_PROG_EN
  localparam bit BOOT_PROG_EN = 1'b1;
`else
  localparam bit BOOT_PROG_EN = 1'b0;
`endif

  // Image word for a given address; NOP past the end of the image or when
  // the boot program is compiled out.
  function automatic logic [31:0] boot_word(input logic [31:0] addr);
    if (BOOT_PROG_EN && (addr < 32'(BOOT_LEN))) begin
      return BOOT_IMAGE[addr[2:0]];
    end
    return NOP;
  endfunction

endpackage

// File: rtl/instr_mem_load_fsm.sv
// rtl/instr_mem_load_fsm.sv - init/load sequencer for the loadable instruction memory
//
// Owns the INIT/IDLE/LOAD state, the shared word counter and the load port
// handshake. Produces the array write strobe and address for the top.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ld_start            open a load session (IDLE only)
//   ld_valid, ld_last   loader word valid / final word of session
//   busy                high in INIT and LOAD
//   ld_ready            accepting words (LOAD)
//   ld_done             one-cycle pulse after the terminating transfer
//   ld_count            words written in current or last session
//   wr_en               array write strobe this cycle
//   wr_boot             write data is the boot image word (INIT), else ld_data
//   wr_addr             array write address
module instr_mem_load_fsm
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              busy,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              wr_en,
  output logic              wr_boot,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              xfer;

  assign xfer    = ld_valid && ld_ready;
  assign wr_en   = (state == INIT) || xfer;
  assign wr_boot = (state == INIT);
  assign wr_addr = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      cnt      <= '0;
      busy     <= 1'b1;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      ld_count <= '0;
    end else begin
      ld_done <= 1'b0;
      unique case (state)
        INIT: begin
          if (cnt == LAST_ADDR) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            ld_ready <= 1'b1;
            cnt      <= '0;
            ld_count <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            ld_count <= ld_count + 1'b1;
            // The top word ends the session even without ld_last: no wrap.
            if (ld_last || (cnt == LAST_ADDR)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= INIT;
          cnt      <= '0;
          busy     <= 1'b1;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - runtime-loadable instruction memory with asynchronous read
//
// DEPTH-word array filled with a boot image after reset, then overwritable
// through a valid/ready load port. Reads return NOP while busy or out of range.
// Optional feature macro: INSTR_MEM_BOOT_PROG_EN (boot program vs all-zero image).
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   A, RD                         fetch address, combinational instruction out
//   busy                          CPU must hold PC while high
//   ld_start, ld_valid, ld_last   load session control
//   ld_data                       word to write
//   ld_ready, ld_done, ld_count   load port status
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] RD,
  output logic              busy,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("instr_mem_loadable: DEPTH must be in 1..2**ADDR_W");
    end
  endgenerate

  logic              wr_en;
  logic              wr_boot;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  instr_mem_load_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .busy     (busy),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_count (ld_count),
    .wr_en    (wr_en),
    .wr_boot  (wr_boot),
    .wr_addr  (wr_addr)
  );

  assign wr_data = wr_boot ? DATA_W'(boot_word(32'(wr_addr))) : ld_data;

  // Array has no reset: INIT rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  assign in_range = {1'b0, A} < (ADDR_W + 1)'(DEPTH);
  assign RD       = (!busy && in_range) ? mem[A[IDX_W-1:0]] : DATA_W'(NOP);

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - self-checking bench for instr_mem_loadable (DEPTH=256 and DEPTH=4)
module tb_instr_mem_loadable;

`ifdef INSTR_MEM_BOOT_PROG_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  a_A = '0, b_A = '0;
  logic [31:0] a_RD, b_RD;
  logic        a_busy, b_busy;
  logic        a_ld_start = 0, a_ld_valid = 0, a_ld_last = 0;
  logic        b_ld_start = 0, b_ld_valid = 0, b_ld_last = 0;
  logic [31:0] a_ld_data = '0, b_ld_data = '0;
  logic        a_ld_ready, b_ld_ready, a_ld_done, b_ld_done;
  logic [8:0]  a_ld_count, b_ld_count;

  instr_mem_loadable #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut_a (
    .clk(clk), .reset(reset), .A(a_A), .RD(a_RD), .busy(a_busy),
    .ld_start(a_ld_start), .ld_valid(a_ld_valid), .ld_last(a_ld_last),
    .ld_data(a_ld_data), .ld_ready(a_ld_ready), .ld_done(a_ld_done),
    .ld_count(a_ld_count)
  );

  instr_mem_loadable #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .A(b_A), .RD(b_RD), .busy(b_busy),
    .ld_start(b_ld_start), .ld_valid(b_ld_valid), .ld_last(b_ld_last),
    .ld_data(b_ld_data), .ld_ready(b_ld_ready), .ld_done(b_ld_done),
    .ld_count(b_ld_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference contents: [0] = DEPTH 256 instance, [1] = DEPTH 4 instance.
  logic [31:0] ref_mem [2][256];
  logic [31:0] words [$];

  logic        sel_b = 1'b0;
  logic        s_ready, s_done, s_busy;
  logic [8:0]  s_count;
  logic [31:0] s_rd;
  assign s_ready = sel_b ? b_ld_ready : a_ld_ready;
  assign s_done  = sel_b ? b_ld_done  : a_ld_done;
  assign s_busy  = sel_b ? b_busy     : a_busy;
  assign s_count = sel_b ? b_ld_count : a_ld_count;
  assign s_rd    = sel_b ? b_RD       : a_RD;

  typedef struct {
    bit          on_b;
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  typedef struct {
    bit          v;
    bit          l;
    bit          gap;
    logic [31:0] d;
  } cyc_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_boot(input int i);
    logic [31:0] w;
    case (i)
      0: w = 32'h200100CA;
      1: w = 32'h00211020;
      2: w = 32'h00421820;
      3: w = 32'h00632020;
      4: w = 32'h00842820;
      default: w = 32'h0;
    endcase
    return BOOT_EN ? w : 32'h0;
  endfunction

  task automatic set_in(input logic st, input logic v, input logic l, input logic [31:0] d);
    if (sel_b) begin
      b_ld_start = st; b_ld_valid = v; b_ld_last = l; b_ld_data = d;
    end else begin
      a_ld_start = st; a_ld_valid = v; a_ld_last = l; a_ld_data = d;
    end
  endtask

  // Called at the negedge where reset was just released.
  task automatic wait_init();
    int  na = 0;
    int  nb = 0;
    bit  fin = 0;
    for (int k = 0; k < 1000 && !fin; k++) begin
      if (k == 1) begin
        a_A = 8'($urandom_range(0, 255));
        b_A = 8'($urandom_range(0, 3));
        #1;
        check("a_rd_during_init", a_RD, 0);
        check("b_rd_during_init", b_RD, 0);
      end
      if (a_busy) na++;
      if (b_busy) nb++;
      if (!a_busy && !b_busy) fin = 1;
      else @(negedge clk);
    end
    check("init_terminated", 64'(fin), 1);
    check("a_init_busy_cycles", 64'(na), 256);
    check("b_init_busy_cycles", 64'(nb), 4);
    for (int i = 0; i < 256; i++) begin
      ref_mem[0][i] = exp_boot(i);
      ref_mem[1][i] = (i < 4) ? exp_boot(i) : 32'h0;
    end
  endtask

  task automatic sweep(input bit use_b, input int exp_count);
    int dep = use_b ? 4 : 256;
    check(use_b ? "b_busy_idle" : "a_busy_idle", use_b ? 64'(b_busy) : 64'(a_busy), 0);
    check(use_b ? "b_ld_count_hold" : "a_ld_count_hold",
          use_b ? 64'(b_ld_count) : 64'(a_ld_count), 64'(exp_count));
    for (int i = 0; i < 256; i++) begin
      if (use_b) b_A = 8'(i); else a_A = 8'(i);
      #1;
      check(use_b ? "b_rd_sweep" : "a_rd_sweep", use_b ? 64'(b_RD) : 64'(a_RD),
            (i < dep) ? 64'(ref_mem[use_b][i]) : 64'h0);
    end
  endtask

  // Runs one session from IDLE using the words queue. gap<0: random 0..3
  // idle cycles between words. Model tracks session state independently.
  task automatic run_load(input bit use_b, input int gap, input bit use_last, output int mcount);
    cyc_t q[$];
    int   dep = use_b ? 4 : 256;
    bit   active;
    bit   pend = 0;
    bit   nxt;
    bit   st;
    int   g;
    sel_b = use_b;
    a_A = 8'h0;
    b_A = 8'h0;
    mcount = 0;
    for (int i = 0; i < words.size(); i++) begin
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      if (i > 0) for (int j = 0; j < g; j++) q.push_back('{0, 0, 1, 32'h0});
      q.push_back('{1, use_last && (i == words.size() - 1), 0, words[i]});
    end
    for (int j = 0; j < 3; j++) q.push_back('{0, 0, 0, 32'h0});

    check("idle_ready", 64'(s_ready), 0);
    set_in(1, 0, 0, 0);
    @(negedge clk);
    active = 1;
    foreach (q[c]) begin
      st = q[c].gap && active && ($urandom_range(0, 1) == 1);
      set_in(st, q[c].v, q[c].l, q[c].d);
      #1;
      check("ld_ready", 64'(s_ready), 64'(active));
      check("ld_done", 64'(s_done), 64'(pend));
      check("busy", 64'(s_busy), 64'(active));
      if (active) check("rd_nop_while_loading", 64'(s_rd), 0);
      nxt = 0;
      if (q[c].v && active) begin
        ref_mem[use_b][mcount] = q[c].d;
        mcount++;
        if (q[c].l || mcount == dep) begin
          active = 0;
          nxt = 1;
        end
      end
      @(negedge clk);
      pend = nxt;
    end
    set_in(0, 0, 0, 0);
    check("ld_count", 64'(s_count), 64'(mcount));
    check("session_closed", 64'(active), 0);
    words.delete();
  endtask

  rd_vec_t tbl [12];
  int      cnt;
  int      n;
  bit      ul;

  initial begin
    tbl[0]  = '{0, 8'd0,   BOOT_EN ? 32'h200100CA : 32'h0};
    tbl[1]  = '{0, 8'd1,   BOOT_EN ? 32'h00211020 : 32'h0};
    tbl[2]  = '{0, 8'd2,   BOOT_EN ? 32'h00421820 : 32'h0};
    tbl[3]  = '{0, 8'd3,   BOOT_EN ? 32'h00632020 : 32'h0};
    tbl[4]  = '{0, 8'd4,   BOOT_EN ? 32'h00842820 : 32'h0};
    tbl[5]  = '{0, 8'd5,   32'h0};
    tbl[6]  = '{0, 8'd128, 32'h0};
    tbl[7]  = '{0, 8'd255, 32'h0};
    tbl[8]  = '{1, 8'd0,   BOOT_EN ? 32'h200100CA : 32'h0};
    tbl[9]  = '{1, 8'd3,   BOOT_EN ? 32'h00632020 : 32'h0};
    tbl[10] = '{1, 8'd4,   32'h0};
    tbl[11] = '{1, 8'd200, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_busy", 64'(a_busy), 1);
    check("rst_a_ready", 64'(a_ld_ready), 0);
    check("rst_a_done", 64'(a_ld_done), 0);
    check("rst_a_count", 64'(a_ld_count), 0);
    check("rst_a_rd", 64'(a_RD), 0);
    check("rst_b_busy", 64'(b_busy), 1);
    check("rst_b_ready", 64'(b_ld_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_init();

    // Boot image reads
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].on_b) b_A = tbl[i].addr; else a_A = tbl[i].addr;
      #1;
      check($sformatf("boot_rd_%s_%0d", tbl[i].on_b ? "b" : "a", tbl[i].addr),
            tbl[i].on_b ? 64'(b_RD) : 64'(a_RD), 64'(tbl[i].exp));
    end
    @(negedge clk);

    // Three back-to-back words, last on third
    words = '{32'h11, 32'h22, 32'h33};
    run_load(0, 0, 1, cnt);
    check("three_word_count", 64'(cnt), 3);
    sweep(0, 3);
    @(negedge clk);

    // Gaps of two idle cycles between words
    words = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    run_load(0, 2, 1, cnt);
    sweep(0, 4);
    @(negedge clk);

    // DEPTH=4: six words without ld_last auto-terminate after the fourth
    words = '{32'h101, 32'h202, 32'h303, 32'h404, 32'h505, 32'h606};
    run_load(1, 0, 0, cnt);
    check("autoterm_count", 64'(cnt), 4);
    sweep(1, 4);
    @(negedge clk);

    // Randomised sessions
    for (int s = 0; s < 5; s++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(0, -1, 1, cnt);
      sweep(0, cnt);
      @(negedge clk);
    end
    for (int s = 0; s < 3; s++) begin
      n = $urandom_range(1, 6);
      ul = (n < 4) ? 1'b1 : ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(1, -1, ul, cnt);
      check("rand_b_count", 64'(cnt), 64'((n < 4) ? n : 4));
      sweep(1, cnt);
      @(negedge clk);
    end

    // Reset after the second word of a load
    sel_b = 0;
    set_in(1, 0, 0, 0);
    @(negedge clk);
    set_in(0, 1, 0, 32'hDEAD0001);
    @(negedge clk);
    set_in(0, 1, 0, 32'hDEAD0002);
    @(negedge clk);
    #1;
    check("midload_count_before_rst", 64'(a_ld_count), 2);
    set_in(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(a_busy), 1);
    check("midrst_ready", 64'(a_ld_ready), 0);
    check("midrst_count", 64'(a_ld_count), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_init();
    sweep(0, 0);
    sweep(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, runtime-loadable instruction memory for the single-cycle MIPS datapath. It replaces the fixed decoded program store with a DEPTH-word array behind an asynchronous read port, so single-cycle fetch timing is unchanged. After reset, an init sequencer fills the array with a boot image. A valid/ready load port then lets an external loader (switch/UART front end) overwrite the program word by word, with a busy output that stalls the CPU.

## Interface
- ADDR_W, 8: fetch/load address width.
- DATA_W, 32: instruction width.
- DEPTH, 256: number of words. Must be in 1..2**ADDR_W; checked at elaboration.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears FSM and counters.
- A  input  ADDR_W  fetch word address.
- RD  output  DATA_W  instruction at A (combinational).
- busy  output  1  high during INIT and LOAD; CPU must hold PC.
- ld_start  input  1  request a new load session (sampled in IDLE only).
- ld_valid  input  1  ld_data holds a word.
- ld_last  input  1  qualifies the final word of a session.
- ld_data  input  DATA_W  word to write.
- ld_ready  output  1  memory accepts a word this cycle.
- ld_done  output  1  one-cycle pulse when a session ends.
- ld_count  output  ADDR_W+1  words written in the current or last session.

## Operation
- States: INIT, IDLE, LOAD.
- Reset (any time, including mid-load) forces INIT with word counter = 0. The array is not cleared by reset itself; INIT rewrites every word.
- INIT: writes one word per cycle, boot_word(cnt), to address cnt, then increments cnt. After address DEPTH-1 is written: cnt <= 0, next state IDLE.
- IDLE: busy=0, ld_ready=0. ld_start=1 -> LOAD, cnt <= 0, ld_count <= 0.
- LOAD: ld_ready=1. On ld_valid&&ld_ready: mem[cnt] <= ld_data, cnt++, ld_count++.
  - The session ends (-> IDLE, ld_done pulse next cycle) when the accepted word has ld_last=1, or when it is the word at address DEPTH-1 (auto-terminate, no wrap).
  - ld_valid=0 in LOAD: no write, stay in LOAD indefinitely.
  - ld_start in LOAD: ignored.
- Read:
  - RD = mem[A] when A < DEPTH and busy=0.
  - RD = 32'h0000_0000 (NOP) when A >= DEPTH or busy=1.
- Partial load: words not written in a session keep their previous contents.

## Timing
- Reset values: busy=1 (INIT), ld_ready=0, ld_done=0, ld_count=0, RD=0.
- INIT lasts exactly DEPTH cycles after reset deasserts; busy falls on the cycle after the last init write.
- Read latency is 0 cycles (combinational).
- A word written at edge N is visible on RD from edge N onward, once busy=0.
- Handshake:
  - A transfer occurs on the edge where ld_valid&&ld_ready.
  - The loader must hold ld_data, ld_valid and ld_last stable until that transfer.
  - Max throughput is 1 word/cycle.
- ld_done is high for exactly one cycle, the cycle after the terminating transfer. busy=0 in that cycle.
- ld_count holds its value in IDLE until the next ld_start.

## Configuration
- INSTR_MEM_BOOT_PROG_EN defined: the INIT image is the boot program below, with all other words 0.
  - 0: 0x200100CA (ADDI $1,$0,0xCA)
  - 1: 0x00211020 (ADD $2,$1,$1)
  - 2: 0x00421820 (ADD $3,$2,$2)
  - 3: 0x00632020 (ADD $4,$3,$3)
  - 4: 0x00842820 (ADD $5,$4,$4)
- Undefined: INIT writes 0 to every word. The CPU executes NOPs until a program is loaded.

## Structure
- Package instr_mem_pkg holds:
  - state_t enum {INIT, IDLE, LOAD}
  - NOP constant
  - boot image as a localparam array, with a function boot_word(addr) returning 0 beyond its length
- Sub-module instr_mem_load_fsm owns the FSM, counter, busy/ld_ready/ld_done/ld_count and the write strobe/address. The top owns the array and the read mux.

## Test plan
- Reset, macro defined, DEPTH=256:
  - busy=1 for 256 cycles, then 0.
  - A=0..4 reads 0x200100CA, 0x00211020, 0x00421820, 0x00632020, 0x00842820.
  - A=5 reads 0.
- Macro undefined: after INIT, A=0 reads 0. Reading during INIT returns 0 at every address.
- ld_start, then 3 back-to-back words 0x11, 0x22, 0x33 with ld_last on the third:
  - ld_done pulses once; ld_count=3.
  - A=0..2 return 0x11, 0x22, 0x33; A=3 is unchanged.
- ld_valid toggled with gaps of 2 idle cycles between words: only valid cycles write, and ld_count equals the number of transfers.
- DEPTH=4, load 6 words with no ld_last:
  - Session auto-ends after the 4th word; ld_ready=0 afterwards.
  - Extra words are not accepted; ld_count=4.
- Reset asserted after the 2nd word of a load: INIT restarts, the boot image is restored, and busy stays high for DEPTH cycles.
